// File: rtl/imem_word_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_responder
// Purpose  : Word-organised memory responder for the fetch-stage read port
//            (read/address -> valueRead, read_blocked) with a configurable
//            response latency, plus a single-cycle byte-maskable write port.
//            Byte lanes are little-endian: [7:0] holds the even byte.
// Options  : IMEM_BOUNDS_CHECK_EN - when defined, out-of-range reads return
//            zero, out-of-range writes are dropped, and addr_error pulses.
//            When undefined, addresses wrap modulo DEPTH and addr_error = 0.
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_responder #(
  parameter int AW      = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          read,
  input  logic [AW-1:0] address,
  output logic [15:0]   valueRead,
  output logic          read_blocked,
  input  logic          write,
  input  logic [AW-1:0] wr_address,
  input  logic [15:0]   wr_data,
  input  logic [1:0]    wr_mask,
  output logic          addr_error
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   value_q;
  logic          blocked_q;
  logic [15:0]   mem_q [DEPTH];

  // Address used by the array read: the live bus in IDLE (LATENCY=1 responds
  // at the acceptance edge), the latched request address while waiting.
  logic [AW-1:0] rd_addr_d;
  logic [15:0]   rd_word_d;
  logic          rd_oob_d;
  logic          wr_oob_d;

  assign rd_addr_d = (state_q == IDLE) ? address : addr_q;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic rd_err_q;
  logic wr_err_q;

  assign rd_oob_d   = ({1'b0, rd_addr_d} >= DEPTH_W);
  assign wr_oob_d   = ({1'b0, wr_address} >= DEPTH_W);
  assign addr_error = rd_err_q | wr_err_q;

  // One-cycle error flag for a write that fell outside the array.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= write && wr_oob_d;
    end
  end
`else
  assign rd_oob_d   = 1'b0;
  assign wr_oob_d   = 1'b0;
  assign addr_error = 1'b0;
`endif

  // Upper address bits above the index are only meaningful for bounds checks.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address, wr_address, addr_q};

  // The array is sampled at the response edge, so writes during WAIT show up.
  assign rd_word_d = rd_oob_d ? 16'h0000 : mem_q[rd_addr_d[IW-1:0]];

  // Read-request FSM: accept in IDLE, count down in WAIT, deliver on count 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      value_q   <= 16'h0000;
      blocked_q <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      rd_err_q  <= 1'b0;
`endif
    end else begin
`ifdef IMEM_BOUNDS_CHECK_EN
      rd_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (read) begin
            addr_q <= address;
            if (LATENCY == 1) begin
              value_q <= rd_word_d;
`ifdef IMEM_BOUNDS_CHECK_EN
              rd_err_q <= rd_oob_d;
`endif
            end else begin
              blocked_q <= 1'b1;
              cnt_q     <= CNT_INIT;
              state_q   <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            value_q   <= rd_word_d;
            blocked_q <= 1'b0;
            state_q   <= IDLE;
`ifdef IMEM_BOUNDS_CHECK_EN
            rd_err_q  <= rd_oob_d;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte-masked write port; independent of the read FSM and never reset.
  always_ff @(posedge clock) begin
    if (write && !wr_oob_d) begin
      if (wr_mask[0]) mem_q[wr_address[IW-1:0]][7:0]  <= wr_data[7:0];
      if (wr_mask[1]) mem_q[wr_address[IW-1:0]][15:8] <= wr_data[15:8];
    end
  end

  assign valueRead    = value_q;
  assign read_blocked = blocked_q;

endmodule
`default_nettype wire

// File: doc/imem_word_responder.md
Name: imem_word_responder

Overview:
- Word-organised memory responder: the far end of the fetch stage's word-read interface (read/address → valueRead, read_blocked).
- Returns one 16-bit word per accepted request after a configurable latency; asserts read_blocked while a request is in flight.
- Also exposes a single-cycle byte-maskable write port, used by the memory stage and by loaders.
- Little-endian byte lanes: the byte at even byte address 2A is in [7:0]; the byte at 2A+1 is in [15:8].

Parameters:
- AW, 10, word-address width.
- DEPTH, 1024, number of 16-bit words; a power of two not exceeding 2^AW.
- LATENCY, 1, cycles from request acceptance to valid data; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- read  in  1  read request, held by the requester
- address  in  AW  word address of the read
- valueRead  out  16  read data word
- read_blocked  out  1  responder busy; requester must hold read and address
- write  in  1  write strobe, single cycle
- wr_address  in  AW  word address of the write
- wr_data  in  16  write data
- wr_mask  in  2  byte enables; bit0 → [7:0], bit1 → [15:8]
- addr_error  out  1  out-of-range access flag (see Optional Feature)

Behaviour:
- Reset, sampled at the clock edge with reset_n=0:
  - valueRead=0, read_blocked=0, addr_error=0, state=IDLE, latency counter=0.
  - Memory contents are not cleared.
- States: IDLE, WAIT.
- IDLE:
  - read=1 at an edge means the request is accepted and address is latched as A.
  - LATENCY=1: at that same edge valueRead←mem[A]. Data is valid the following cycle and read_blocked stays 0. This supports back-to-back reads at one word per cycle with address incrementing each cycle.
  - LATENCY=N>1: at that edge read_blocked←1, counter←N-1, go to WAIT.
- WAIT:
  - Counter decrements each edge. read and address are ignored.
  - On the edge where the counter equals 1: valueRead←mem[A], read_blocked←0, go to IDLE. Data is valid N cycles after acceptance.
- read=0 in IDLE: valueRead holds its last value.
- Array read timing: mem[A] is read at the response edge, not the acceptance edge. A write to A during WAIT is therefore visible in the returned word.
- Write path:
  - write=1 updates the enabled bytes of mem[wr_address] at the edge, independent of read state.
  - wr_mask=00 is a no-op.
- Same-edge read response and write to the same word: read-first. valueRead gets the old word; the array gets the new one.
- Address wrap: addresses are taken modulo DEPTH (low log2(DEPTH) bits) unless the macro below is enabled.
- Reset during WAIT aborts the request: read_blocked=0 next cycle, valueRead=0, no response is delivered.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - An accepted read with address>=DEPTH returns valueRead=0x0000 with normal latency.
  - A write with wr_address>=DEPTH is dropped.
  - Either event pulses addr_error=1 for exactly one cycle: the cycle after the response edge for reads, the cycle after the write edge for writes.
- Undefined: addr_error tied to 0; addresses wrap modulo DEPTH.

Test Plan:
- LATENCY=1; write mem[5]=0x3020 mask 11, then read=1 address=5 → valueRead=0x3020 the next cycle, read_blocked never 1.
- LATENCY=1; read held for addresses 8,9,10 on consecutive cycles with mem=0x1111/0x2222/0x3333 → valueRead follows at one-cycle lag with those values.
- LATENCY=3; read address=2 (mem[2]=0xABCD) → read_blocked=1 for 2 cycles, valueRead=0xABCD valid 3 cycles after acceptance. An address change during WAIT is ignored.
- LATENCY=3; during WAIT for address 2, write 0x00EE mask 01 to word 2 → returned valueRead=0xABEE.
- LATENCY=4; reset_n=0 one cycle mid-WAIT → read_blocked=0 and valueRead=0 the next cycle; a new request is accepted immediately after.
- With IMEM_BOUNDS_CHECK_EN, DEPTH=256, AW=10; read address=300 → valueRead=0x0000 and a single-cycle addr_error pulse. Without the macro, the same read returns mem[44].
